lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store unit controller between the RV32I core's execute stage and the data memory. It accepts one load or store per handshake and validates alignment and range. For stores it builds the byte mask and lane-replicated write data; for loads it issues the memory read, waits for `valid`, then extracts and sign/zero-extends the addressed byte, halfword or word. The core stalls on `busy`.

## Interface
Parameters:
- `ADDR_W`, 8: memory word-address width; byte-address space is 2^(ADDR_W+2) bytes.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `lsu_req`  in  1  core request, sampled only in IDLE.
- `lsu_we`  in  1  1 = store, 0 = load.
- `lsu_funct3`  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `lsu_addr`  in  32  byte address.
- `lsu_wdata`  in  32  store data; low byte/half used for SB/SH.
- `lsu_busy`  out  1  high whenever state ≠ IDLE.
- `lsu_done`  out  1  one-cycle completion pulse.
- `lsu_err`  out  1  valid with `lsu_done`; misaligned, out-of-range or illegal funct3.
- `lsu_rdata`  out  32  load result, valid with `lsu_done`; held until the next completion.
- `mem_request`  out  1  memory request.
- `mem_we_re`  out  1  1 = write, 0 = read.
- `mem_address`  out  ADDR_W  word address, `lsu_addr[ADDR_W+1:2]`.
- `mem_data_in`  out  32  lane-replicated write data.
- `mem_mask`  out  4  byte-lane write enables.
- `mem_valid`  in  1  memory read-data valid (sticky, not a pulse).
- `mem_data_out`  in  32  memory read word.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE + `lsu_req`: latch `we`, `funct3` and `addr`; latch the store data already replicated.
  - If an error condition holds: go to DONE with err=1 and no memory access.
  - Otherwise: go to ISSUE.
- ISSUE: `mem_request`=1 for exactly this cycle; `mem_we_re`=latched we. Store → DONE. Load → WAIT.
- WAIT: on `mem_valid`=1, capture the extracted word into `lsu_rdata` and go to DONE; otherwise stay in WAIT.
- DONE: `lsu_done`=1 for one cycle, then IDLE.
- Error conditions:
  - Halfword access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
  - `addr[31:ADDR_W+2]`≠0.
  - Load funct3 ∈ {3,6,7}; store funct3 ≥ 3.
- Store mask:
  - SB: `4'b0001 << addr[1:0]`, data `{4{wdata[7:0]}}`.
  - SH: `addr[1]` ? `1100` : `0011`, data `{2{wdata[15:0]}}`.
  - SW: `1111`, data as given.
- Load extract:
  - Byte: `mem_data_out[8*addr[1:0] +: 8]`, sign-extend for LB, zero-extend for LBU.
  - Half: `mem_data_out[16*addr[1] +: 16]`, sign-extend for LH, zero-extend for LHU.
  - Word: passed unchanged.
- `lsu_req` while busy is ignored; the core must hold the request until it sees `lsu_done`.
- Outside ISSUE, `mem_request`=0 and `mem_mask`=0.
- Memory side fields (`mem_address`, `mem_data_in`, `mem_we_re`) are driven from latched registers, stable throughout ISSUE.

## Timing
- Reset values:
  - State: IDLE.
  - `lsu_busy`, `lsu_done`, `lsu_err`, `mem_request`, `mem_we_re`: 0.
  - `mem_mask`: 0; `mem_address`: 0; `mem_data_in`: 0; `lsu_rdata`: 0.
- Reset asserted mid-operation: immediate return to IDLE, no `lsu_done`; an in-flight memory write may or may not have landed.
- Accept edge = cycle 0.
- Store: ISSUE in cycle 1 (memory writes at end of cycle 1); `lsu_done` in cycle 2.
- Load: ISSUE in cycle 1; WAIT in cycle 2 (`mem_valid` expected high); `lsu_done` with `lsu_rdata` in cycle 3.
- Error: `lsu_done`+`lsu_err` in cycle 1.
- Back-to-back: the next request is accepted in the cycle after DONE, i.e. it is sampled in IDLE.
- Because `mem_valid` is sticky, WAIT is entered only after ISSUE; read data is always taken from the cycle after the read request.

## Structure
- `lsu_pkg`: funct3 localparams (F3_B/H/W/BU/HU) and the state enum/encoding.
- Sub-module `lsu_align`, purely combinational:
  - Inputs: funct3, `addr[1:0]`, wdata, rdata.
  - Outputs: mask, replicated write data, extracted load data, misalign flag.
- `lsu_ctrl` holds the FSM and latches.

## Test plan
- SB addr 0x0000_0005, wdata 0xAB → ISSUE cycle shows mask `0010`, `mem_address`=1, `mem_data_in`=0xABABABAB; `lsu_done` 2 cycles after accept, err=0.
- Memory word 0 = 0x80FF_7F01.
  - LB addr 0x2 → `lsu_rdata`=0xFFFF_FFFF.
  - LBU addr 0x3 → 0x0000_0080.
  - LH addr 0x2 → 0xFFFF_80FF.
  - Each completes 3 cycles after accept.
- SH addr 0x3 → `lsu_err`=1, `lsu_done` in cycle 1, `mem_request` never asserted.
- LW addr 0x0000_0400 (out of range for ADDR_W=8) → err=1, no request.
- SW 0x1234_5678 to addr 0x10 followed by LW addr 0x10 back-to-back → `lsu_rdata`=0x1234_5678. `lsu_req` pulsed during busy is ignored.
- Reset `rst_n` low during WAIT → all outputs 0 immediately. After release, an LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit.
// funct3 codes and controller state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit.
// Builds store mask/data, extracts load data, flags misalignment.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        misalign_o
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    assign byte_sh = rdata_i >> {addr_i, 3'b000};
    assign half_sh = rdata_i >> {addr_i[1], 4'b0000};

    // Store side: lane mask, replicated data and alignment by access size.
    always_comb begin
        mask_o     = 4'b0000;
        wdata_o    = wdata_i;
        misalign_o = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                mask_o  = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                mask_o     = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_i[0];
            end
            2'b10: begin
                mask_o     = 4'b1111;
                misalign_o = |addr_i;
            end
            default: begin
                mask_o     = 4'b0000;
                misalign_o = 1'b0;
            end
        endcase
    end

    // Load side: pick the addressed lane(s) and extend.
    always_comb begin
        ldata_o = rdata_i;
        case (funct3_i)
            F3_B:    ldata_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
            F3_BU:   ldata_o = {24'b0, byte_sh[7:0]};
            F3_H:    ldata_o = {{16{half_sh[15]}}, half_sh[15:0]};
            F3_HU:   ldata_o = {16'b0, half_sh[15:0]};
            default: ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between execute stage and data memory.
// One request per handshake; IDLE -> ISSUE -> (WAIT) -> DONE.
module lsu_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_funct3,
    input  logic [31:0]       lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic [31:0]       lsu_rdata,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic [3:0]        mem_mask,
    input  logic              mem_valid,
    input  logic [31:0]       mem_data_out
);

    import lsu_pkg::*;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        mask_q, mask_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic        idle;
    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [3:0]  al_mask;
    logic [31:0] al_wdata;
    logic [31:0] al_ldata;
    logic        al_mis;
    logic        ill_f3;
    logic        oor;
    logic        err_c;

    assign idle = (state_q == S_IDLE);

    // Align unit sees live request in IDLE, latched request afterwards.
    assign al_f3  = idle ? lsu_funct3 : f3_q;
    assign al_off = idle ? lsu_addr[1:0] : off_q;

    lsu_align u_align (
        .funct3_i   (al_f3),
        .addr_i     (al_off),
        .wdata_i    (lsu_wdata),
        .rdata_i    (mem_data_out),
        .mask_o     (al_mask),
        .wdata_o    (al_wdata),
        .ldata_o    (al_ldata),
        .misalign_o (al_mis)
    );

    assign ill_f3 = lsu_we ? (lsu_funct3 >= 3'd3)
                           : (lsu_funct3 == 3'd3 ||
                              lsu_funct3[2:1] == 2'b11);
    assign oor    = |(lsu_addr >> (ADDR_W + 2));
    assign err_c  = ill_f3 | oor | al_mis;

    // Next-state and latch logic for the request FSM.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_req) begin
                    we_d    = lsu_we;
                    f3_d    = lsu_funct3;
                    off_d   = lsu_addr[1:0];
                    waddr_d = lsu_addr[ADDR_W+1:2];
                    wdata_d = al_wdata;
                    mask_d  = al_mask;
                    err_d   = err_c;
                    state_d = err_c ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: state_d = we_q ? S_DONE : S_WAIT;
            S_WAIT: begin
                if (mem_valid) begin
                    rdata_d = al_ldata;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            off_q   <= 2'b0;
            waddr_q <= '0;
            wdata_q <= 32'b0;
            mask_q  <= 4'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign lsu_busy    = !idle;
    assign lsu_done    = (state_q == S_DONE);
    assign lsu_err     = lsu_done & err_q;
    assign lsu_rdata   = rdata_q;
    assign mem_request = (state_q == S_ISSUE);
    assign mem_we_re   = we_q;
    assign mem_address = waddr_q;
    assign mem_data_in = wdata_q;
    assign mem_mask    = mem_request ? mask_q : 4'b0000;

endmodule
